// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder and its
// combinational digit slice.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Wide enough to hold NDIG itself, so the counter never wraps.
  function automatic int cnt_width(input int width, input int digit);
    return $clog2(width / digit + 1);
  endfunction

  function automatic bit width_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational ripple adder for one digit. Also exposes the carry into the
// top bit so the caller can form signed overflow on the last digit.
module digit_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ctop
);

  always_comb begin
    logic c;
    c    = ci;
    s    = '0;
    ctop = ci;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) ctop = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/subtract of two WIDTH-bit operands, DIGIT bits per clock,
// least-significant digit first, carry held in a register between digits.
//
// Handshake: an operation is accepted on a rising edge where start=1 and
// ready=1; ready depends on state only. done is a one-cycle pulse in the
// cycle after the last digit, and sum/carry/overflow change only then.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_width(WIDTH, DIGIT);

  generate
    if (!width_ok(WIDTH, DIGIT)) begin : g_bad_params
      $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t                 state, state_n;
  logic                   accept;
  logic                   last;
  logic [WIDTH-1:0]       op_a, op_b, res;
  logic                   cr;
  logic [CW-1:0]          cnt;
  logic [DIGIT-1:0]       d_s;
  logic                   d_co, d_ctop;
  logic [WIDTH+DIGIT-1:0] res_cat;

  assign state_dbg = state;
  assign last      = (cnt == CW'(NDIG - 1));
  // New digit enters the result register from the top, so after NDIG
  // shifts the first digit sits at bit 0.
  assign res_cat   = {d_s, res} >> DIGIT;

  digit_adder #(.WIDTH(DIGIT)) u_digit (
    .a    (op_a[DIGIT-1:0]),
    .b    (op_b[DIGIT-1:0]),
    .ci   (cr),
    .s    (d_s),
    .co   (d_co),
    .ctop (d_ctop)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      cr       <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
      op_a <= a;
      op_b <= sub ? ~b : b;
      cr   <= sub ? 1'b1 : cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      op_a <= op_a >> DIGIT;
      op_b <= op_b >> DIGIT;
      res  <= res_cat[WIDTH-1:0];
      cr   <= d_co;
      cnt  <= cnt + 1'b1;
      if (last) begin
        sum      <= res_cat[WIDTH-1:0];
        carry    <= d_co;
        overflow <= d_ctop ^ d_co;
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three instances (DIGIT = 1, 4, 16) checked
// against an integer-arithmetic reference model.
module tb_digit_serial_adder;

  localparam int W = 16;
  int nd [3] = '{16, 4, 1};

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start_v [3];
  logic         sub_v   [3];
  logic         cin_v   [3];
  logic [W-1:0] a_v     [3];
  logic [W-1:0] b_v     [3];
  logic         ready_v [3];
  logic         done_v  [3];
  logic [W-1:0] sum_v   [3];
  logic         carry_v [3];
  logic         ovf_v   [3];
  logic [1:0]   st_v    [3];

  digit_serial_adder #(.WIDTH(W), .DIGIT(1)) dut_d1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .sub(sub_v[0]), .a(a_v[0]),
    .b(b_v[0]), .cin(cin_v[0]), .ready(ready_v[0]), .done(done_v[0]),
    .sum(sum_v[0]), .carry(carry_v[0]), .overflow(ovf_v[0]), .state_dbg(st_v[0]));

  digit_serial_adder #(.WIDTH(W), .DIGIT(4)) dut_d4 (
    .clk(clk), .reset(reset), .start(start_v[1]), .sub(sub_v[1]), .a(a_v[1]),
    .b(b_v[1]), .cin(cin_v[1]), .ready(ready_v[1]), .done(done_v[1]),
    .sum(sum_v[1]), .carry(carry_v[1]), .overflow(ovf_v[1]), .state_dbg(st_v[1]));

  digit_serial_adder #(.WIDTH(W), .DIGIT(16)) dut_d16 (
    .clk(clk), .reset(reset), .start(start_v[2]), .sub(sub_v[2]), .a(a_v[2]),
    .b(b_v[2]), .cin(cin_v[2]), .ready(ready_v[2]), .done(done_v[2]),
    .sum(sum_v[2]), .carry(carry_v[2]), .overflow(ovf_v[2]), .state_dbg(st_v[2]));

  // scoreboard: {carry, overflow, sum}
  logic [W+1:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer result, carry = result fits/no-borrow test,
  // overflow = signed result outside the 16-bit signed range.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s, input logic c);
    longint ua = longint'(x);
    longint ub = longint'(y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint r, sr;
    logic cy, ov;
    if (!s) begin
      r  = ua + ub + longint'(c);
      sr = sx + sy + longint'(c);
      cy = (r >= 65536);
    end else begin
      r  = ua - ub;
      sr = sx - sy;
      cy = (ua >= ub);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {cy, ov, r[W-1:0]};
  endfunction

  // driver: launches one operation and checks its completion. With hold=1,
  // start stays high (with scrambled operands) through RUN. With chain=1 it
  // returns inside the DONE cycle so the next call starts back-to-back.
  task automatic do_op(input int k, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic ts, input logic tc, input bit hold, input bit chain);
    logic [W-1:0] prev;
    logic [W+1:0] e;
    int cyc;
    bit stable, rdy_ok;
    exp_q.push_back(ref_model(ta, tb, ts, tc));
    prev = sum_v[k];
    a_v[k] = ta; b_v[k] = tb; sub_v[k] = ts; cin_v[k] = tc;
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      a_v[k] = ~ta; b_v[k] = tb ^ 16'h5a5a; sub_v[k] = ~ts; cin_v[k] = ~tc;
    end else begin
      start_v[k] = 1'b0;
    end
    cyc = 1; stable = 1'b1; rdy_ok = 1'b1;
    while (done_v[k] !== 1'b1 && cyc <= nd[k] + 8) begin
      if (sum_v[k] !== prev) stable = 1'b0;
      if (ready_v[k] !== 1'b0) rdy_ok = 1'b0;
      if (hold && cyc == nd[k]) start_v[k] = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start_v[k] = 1'b0;
    e = exp_q.pop_front();
    chk($sformatf("latency_k%0d", k), cyc, nd[k] + 1);
    chk($sformatf("done_k%0d", k), done_v[k], 1);
    chk($sformatf("ready_done_k%0d", k), ready_v[k], 1);
    chk($sformatf("sum_k%0d a=%h b=%h s=%0d", k, ta, tb, ts), sum_v[k], e[W-1:0]);
    chk($sformatf("carry_k%0d a=%h b=%h s=%0d", k, ta, tb, ts), carry_v[k], e[W+1]);
    chk($sformatf("ovf_k%0d a=%h b=%h s=%0d", k, ta, tb, ts), ovf_v[k], e[W]);
    chk($sformatf("sum_hold_k%0d", k), stable, 1);
    chk($sformatf("ready_run_k%0d", k), rdy_ok, 1);
    if (!chain) begin
      @(posedge clk); #1;
      chk($sformatf("done_pulse_k%0d", k), done_v[k], 0);
      chk($sformatf("ready_idle_k%0d", k), ready_v[k], 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit no_done;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; sub_v[k] = 1'b0; cin_v[k] = 1'b0;
      a_v[k] = '0; b_v[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready_k%0d", k), ready_v[k], 1);
      chk($sformatf("rst_done_k%0d", k), done_v[k], 0);
      chk($sformatf("rst_sum_k%0d", k), sum_v[k], 0);
      chk($sformatf("rst_carry_k%0d", k), carry_v[k], 0);
      chk($sformatf("rst_ovf_k%0d", k), ovf_v[k], 0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // directed steps on the DIGIT=4 instance
    do_op(1, 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 0);
    do_op(1, 16'h1234, 16'h4321, 1'b0, 1'b1, 0, 0);
    do_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0);
    do_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 0);
    do_op(1, 16'h0005, 16'h0007, 1'b1, 1'b1, 0, 0);
    do_op(1, 16'h8000, 16'h0001, 1'b1, 1'b0, 0, 0);
    do_op(1, 16'h0F0F, 16'h1111, 1'b0, 1'b0, 1, 0);
    do_op(1, 16'hABCD, 16'h1234, 1'b0, 1'b1, 0, 1);
    do_op(1, 16'h00FF, 16'h0F00, 1'b1, 1'b0, 0, 0);

    // reset in the middle of RUN: no done, outputs cleared
    a_v[1] = 16'h1111; b_v[1] = 16'h2222; sub_v[1] = 1'b0; cin_v[1] = 1'b0;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_ready", ready_v[1], 1);
    chk("midrst_done", done_v[1], 0);
    chk("midrst_sum", sum_v[1], 0);
    chk("midrst_carry", carry_v[1], 0);
    chk("midrst_ovf", ovf_v[1], 0);
    no_done = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_v[1] !== 1'b0) no_done = 1'b0;
    end
    chk("midrst_no_done", no_done, 1);

    // random sweep over all three digit sizes, random back-to-back chaining
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 1000; n++) begin
        do_op(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 0, (n != 999) && ($urandom_range(0, 1) == 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised multi-cycle adder/subtractor that processes two WIDTH-bit operands DIGIT bits per clock, least-significant digit first, with a ripple carry held in a register between cycles. It is the sequential, wide-operand successor to the single-bit half adder. It trades latency for area in datapaths where a full-width carry chain is too large or too slow. Operands enter through a start/ready handshake, and results are held on registered outputs until the next accepted operation.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- Clk  input  1  single clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only while Ready=1.
- Sub  input  1  0 = add, 1 = subtract; captured with Start.
- A  input  WIDTH  first operand; captured with Start.
- B  input  WIDTH  second operand; captured with Start.
- Cin  input  1  carry-in for add; ignored when Sub=1.
- Ready  output  1  block can accept Start this cycle.
- Done  output  1  one-cycle pulse; results valid.
- Sum  output  WIDTH  result, registered.
- Carry  output  1  final carry-out; for Sub=1, a value of 1 means no borrow.
- Overflow  output  1  two's-complement signed overflow.

## Operation
- NDIG = WIDTH/DIGIT.
- **Function:**
  - Sub=0: {Carry,Sum} = A + B + Cin.
  - Sub=1: {Carry,Sum} = A + ~B + 1.
  - Overflow = carry into the MSB XOR carry out of the MSB.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE: Ready=1. If Start=1, capture A, B (inverted if Sub) and the initial carry (Cin or 1), clear the digit counter, then go to RUN.
  - RUN: Ready=0. Each cycle, add the current low digits plus the carry register, shift the result digit into the internal result shift register from the top, shift the operand registers right by DIGIT, and update the carry register. After NDIG cycles, load Sum, Carry and Overflow, then go to DONE.
  - DONE: Done=1 and Ready=1. If Start=1, capture new operands and go to RUN (back-to-back operation). Otherwise go to IDLE.
- Start while Ready=0 is ignored and has no effect on the operation in progress.
- Sum, Carry and Overflow change only on the completion edge. They hold their previous values throughout RUN and until the next completion.
- Reset at any time, including mid-RUN:
  - state returns to IDLE; Ready=1, Done=0, Sum=0, Carry=0, Overflow=0.
  - the aborted operation produces no Done pulse.
- The digit counter is ceil(log2(NDIG+1)) bits wide and never wraps within an operation.

## Timing
- Start=1 with Ready=1 in cycle 0 → RUN occupies cycles 1..NDIG → Done=1 and new outputs are visible in cycle NDIG+1.
- Latency is NDIG+1 cycles. Back-to-back throughput is one result per NDIG+1 cycles.
- Ready is combinational from state only, never from Start.
- Done is high for exactly one cycle per accepted Start.
- When DIGIT = WIDTH: NDIG=1 and latency is 2.

## Structure
- Shared package `adder_pkg`:
  - state enum {IDLE, RUN, DONE};
  - function computing NDIG and the counter width;
  - elaboration check that WIDTH % DIGIT == 0.
- Sub-module `digit_adder`: combinational DIGIT-bit ripple adder. Inputs: a, b, ci. Outputs: s, co, and the carry into its top bit (used for Overflow on the last digit).
- Top level holds the FSM, operand/result shift registers, carry register and digit counter.

## Test plan
WIDTH=16, DIGIT=4 unless stated.

1. **Reset:** assert Reset 2 cycles → Ready=1, Done=0, Sum=0x0000, Carry=0, Overflow=0. Then Start=1, assert Reset in cycle 2 → no Done, Ready=1 the following cycle.
2. **Add, no carry-out:** A=0x1234, B=0x4321, Cin=0, Sub=0 → Done in cycle 5, Sum=0x5555, Carry=0, Overflow=0. Same operands with Cin=1 → Sum=0x5556.
3. **Carry ripple and signed overflow:**
   - A=0xFFFF, B=0x0001 → Sum=0x0000, Carry=1, Overflow=0.
   - A=0x7FFF, B=0x0001 → Sum=0x8000, Carry=0, Overflow=1.
4. **Subtract:**
   - A=0x0005, B=0x0007, Sub=1, Cin=1 (ignored) → Sum=0xFFFE, Carry=0, Overflow=0.
   - A=0x8000, B=0x0001, Sub=1 → Sum=0x7FFF, Carry=1, Overflow=1.
5. **Handshake:**
   - Start held high during RUN → ignored; Sum stays at the previous result until cycle 5.
   - Start in the DONE cycle → second result's Done 5 cycles later, with no idle cycle between operations.
6. **Parameter sweep:** DIGIT ∈ {1, 4, 16} with 1000 random operands each, checked against a reference model. Latency must be WIDTH/DIGIT+1 in every case.
